occ_gt_pattern_checker: RTL
===========================

Name: occ_gt_pattern_checker

Overview:
- Receive-side companion to the transceiver tile's test pattern source.
- Pattern on the wire: 16-bit words. When the transmit counter's low G_PERIOD_LOG2 bits are zero, the word is comma 16'hBC95 with charisk 2'b10 (K28.5 in the upper byte). Every other word is the counter value with charisk 2'b00. The counter increments by one every usrclk.
- Block sits on the tile's rx outputs in the usrclk domain. It hunts for the comma, locks, checks every following word against the predicted sequence, and counts word errors and 8b10b code errors for link qualification.

Parameters:
- G_PERIOD_LOG2, 5, log2 of comma period in words.
- G_ERR_THRESHOLD, 4, consecutive word errors that force loss of lock (range 1..15).
- G_CNT_WIDTH, 32, width of the saturating error counters.

Ports:
- clk_i  in  1  usrclk from tile
- rst_i  in  1  synchronous, active-high reset
- rxresetdone_i  in  1  tile rx reset done; low = data invalid
- rxdata_i  in  16  received word
- rxcharisk_i  in  2  K flags per byte, bit1 = upper byte
- rxdisperr_i  in  2  disparity error per byte
- rxnotintable_i  in  2  not-in-table per byte
- clear_i  in  1  synchronous clear of both counters
- locked_o  out  1  checker in LOCKED
- err_o  out  1  one-cycle pulse, word mismatch while LOCKED
- err_cnt_o  out  G_CNT_WIDTH  saturating word-error count
- code_err_cnt_o  out  G_CNT_WIDTH  saturating code-error count
- lock_loss_cnt_o  out  8  saturating count of LOCKED->HUNT transitions

Behaviour:
- Reset values: all outputs 0; state IDLE; expected register 0; consecutive-error counter 0.
- All inputs are sampled on rising clk_i. All outputs are registered. Latency from an input word to its effect on the outputs is 1 cycle.
- IDLE: leave to HUNT on the first cycle with rxresetdone_i=1.
- HUNT: when word == 16'hBC95 and charisk == 2'b10, go to SYNC.
- SYNC: the next word must have charisk 2'b00 and rxdata_i[G_PERIOD_LOG2-1:0]==1.
  - If so: expected <= rxdata_i+1, go to LOCKED.
  - Otherwise: return to HUNT. No error is counted.
- LOCKED, per word:
  - If expected[G_PERIOD_LOG2-1:0]==0, the word must be the comma exactly.
  - Otherwise the word must equal expected with charisk 2'b00.
  - expected <= expected+1 every cycle, regardless of match. Wraps modulo 2^16 (0xFFFF -> 0x0000, and 0x0000 is a comma slot).
  - Mismatch: err_o=1, err_cnt +1, consecutive counter +1.
  - Match: consecutive counter cleared.
  - When the consecutive count reaches G_ERR_THRESHOLD: go to HUNT, lock_loss_cnt +1, consecutive counter cleared.
- locked_o = (state==LOCKED), registered.
- Code errors: code_err_cnt increments by 1 in any cycle with rxresetdone_i=1 and |(rxdisperr_i|rxnotintable_i), in any state other than IDLE. Counts once per cycle, even if both bytes are bad.
- rxresetdone_i falling in any state: go to IDLE next cycle. Counters hold. err_o is 0.
- Counters saturate at all-ones and do not wrap.
- clear_i zeroes all three counters and does not change state. If clear_i coincides with an increment event, clear wins and that event is dropped. err_o still pulses.
- rst_i mid-operation returns everything to reset values on the next edge, with priority over all other inputs.

Optional Feature:
- Macro: OCC_GT_CHECKER_SWAP_EN.
- Defined:
  - HUNT also accepts a byte-swapped comma: 16'h95BC with charisk 2'b01.
  - On that match, a swap flag is set. While set, rxdata_i, rxcharisk_i, rxdisperr_i and rxnotintable_i have their bytes swapped before all checks (adds no latency).
  - Flag is cleared on entry to IDLE or HUNT.
  - Output swapped_o (1 bit) reflects the flag, reset 0.
- Undefined: swapped comma is ignored in HUNT, no swap logic exists, and the swapped_o port is absent.

Decomposition:
- Package occ_gt_checker_pkg holds:
  - c_COMMA_DATA = 16'hBC95
  - c_COMMA_K = 2'b10
  - c_COMMA_DATA_SWAP = 16'h95BC
  - c_COMMA_K_SWAP = 2'b01
  - state encoding IDLE/HUNT/SYNC/LOCKED
- One sub-module, occ_sat_counter: parameterised width, inc and clr inputs, clr priority, saturation. Instantiated three times.

Test Plan:
- Reset, then ideal pattern at counter start 0 with rxresetdone_i=1 -> locked_o=1 by the 3rd word after the first comma; err_cnt_o=0 over 10000 words.
- Locked, corrupt one data word (0x0025 replaced with 0x0000) -> err_o pulses exactly once, one cycle later; err_cnt_o=1; locked_o stays 1.
- Locked, 4 consecutive bad words -> lock_loss_cnt_o=1, locked_o=0; relock on the next comma + word with low bits 1, with err_cnt_o=4.
- rxdisperr_i=2'b11 for 3 cycles -> code_err_cnt_o=3. rxresetdone_i low for 5 cycles -> state IDLE, locked_o=0, counters held.
- Counter wrap 0xFFFF -> 0x0000 with a comma sent in the 0x0000 slot -> no error. clear_i coinciding with an error -> err_cnt_o=0, err_o=1.
- With OCC_GT_CHECKER_SWAP_EN: byte-swapped stream -> swapped_o=1, locked_o=1, err_cnt_o=0. Without the macro, the same stream -> locked_o stays 0.

Source files
------------

// File: rtl/occ_gt_checker_pkg.sv
// Purpose : shared constants and state encoding for the GT pattern checker.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package occ_gt_checker_pkg;

   // K28.5 comma in the upper byte, as sent by the tile pattern source
   localparam logic [15:0] c_COMMA_DATA      = 16'hBC95;
   localparam logic [1:0]  c_COMMA_K         = 2'b10;
   // Same comma as seen when the receiver byte alignment is off by one byte
   localparam logic [15:0] c_COMMA_DATA_SWAP = 16'h95BC;
   localparam logic [1:0]  c_COMMA_K_SWAP    = 2'b01;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HUNT   = 2'd1,
      SYNC   = 2'd2,
      LOCKED = 2'd3
   } state_t;

endpackage

// File: rtl/occ_sat_counter.sv
// Purpose : saturating up-counter with synchronous clear (clear beats increment).
// Latency : count updates on the clock edge that samples inc/clr.
// Backpressure: none; an increment at all-ones is dropped.
// Ports   : clk, rst (sync, active-high), clr, inc, count[WIDTH-1:0].
module occ_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/occ_gt_pattern_checker.sv
// Purpose : hunts for the comma in the rx pattern, locks, and counts word/code errors.
// Latency : 1 cycle from rx word to every output.
// Backpressure: none; one word is consumed every usrclk.
// Ports   : clk_i, rst_i (sync, active-high), rxresetdone_i, rxdata_i[15:0],
//           rxcharisk_i/rxdisperr_i/rxnotintable_i[1:0], clear_i;
//           locked_o, err_o, err_cnt_o, code_err_cnt_o, lock_loss_cnt_o[7:0],
//           swapped_o (only when OCC_GT_CHECKER_SWAP_EN is defined).
// Option  : OCC_GT_CHECKER_SWAP_EN accepts a byte-swapped comma and un-swaps the stream.
module occ_gt_pattern_checker
   import occ_gt_checker_pkg::*;
#(
   parameter int G_PERIOD_LOG2   = 5,
   parameter int G_ERR_THRESHOLD = 4,
   parameter int G_CNT_WIDTH     = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   rxresetdone_i,
   input  logic [15:0]            rxdata_i,
   input  logic [1:0]             rxcharisk_i,
   input  logic [1:0]             rxdisperr_i,
   input  logic [1:0]             rxnotintable_i,
   input  logic                   clear_i,
`ifdef OCC_GT_CHECKER_SWAP_EN
   output logic                   swapped_o,
`endif
   output logic                   locked_o,
   output logic                   err_o,
   output logic [G_CNT_WIDTH-1:0] err_cnt_o,
   output logic [G_CNT_WIDTH-1:0] code_err_cnt_o,
   output logic [7:0]             lock_loss_cnt_o
);

   logic [15:0] data;
   logic [1:0]  charisk;
   logic [1:0]  disperr;
   logic [1:0]  notintable;

   state_t      state_q, state_d;
   logic [15:0] expected_q, expected_d;
   logic [3:0]  consec_q, consec_d;
   logic        word_err;
   logic        lock_loss;
   logic        code_err;
   logic        word_ok;

`ifdef OCC_GT_CHECKER_SWAP_EN
   logic swap_q, swap_d;

   // Byte swap is purely combinational so it adds no latency
   assign data       = swap_q ? {rxdata_i[7:0], rxdata_i[15:8]}   : rxdata_i;
   assign charisk    = swap_q ? {rxcharisk_i[0], rxcharisk_i[1]}  : rxcharisk_i;
   assign disperr    = swap_q ? {rxdisperr_i[0], rxdisperr_i[1]}  : rxdisperr_i;
   assign notintable = swap_q ? {rxnotintable_i[0], rxnotintable_i[1]} : rxnotintable_i;
   assign swapped_o  = swap_q;
`else
   assign data       = rxdata_i;
   assign charisk    = rxcharisk_i;
   assign disperr    = rxdisperr_i;
   assign notintable = rxnotintable_i;
`endif

   // Low counter bits of zero mark a comma slot in the predicted sequence
   always_comb begin
      if (expected_q[G_PERIOD_LOG2-1:0] == '0) begin
         word_ok = (data == c_COMMA_DATA) && (charisk == c_COMMA_K);
      end else begin
         word_ok = (data == expected_q) && (charisk == 2'b00);
      end
   end

   // Code errors are ignored while the tile says data is invalid or we are idle
   assign code_err = rxresetdone_i && (state_q != IDLE) && (|(disperr | notintable));

   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      consec_d   = consec_q;
      word_err   = 1'b0;
      lock_loss  = 1'b0;
`ifdef OCC_GT_CHECKER_SWAP_EN
      swap_d     = swap_q;
`endif
      if (!rxresetdone_i) begin
         state_d  = IDLE;
         consec_d = '0;
`ifdef OCC_GT_CHECKER_SWAP_EN
         swap_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d = HUNT;
            end
            HUNT: begin
               if ((data == c_COMMA_DATA) && (charisk == c_COMMA_K)) begin
                  state_d = SYNC;
               end
`ifdef OCC_GT_CHECKER_SWAP_EN
               else if ((rxdata_i == c_COMMA_DATA_SWAP) && (rxcharisk_i == c_COMMA_K_SWAP)) begin
                  state_d = SYNC;
                  swap_d  = 1'b1;
               end
`endif
            end
            SYNC: begin
               // The word after the comma must be counter value with low bits == 1
               if ((charisk == 2'b00) && (data[G_PERIOD_LOG2-1:0] == G_PERIOD_LOG2'(1))) begin
                  expected_d = data + 16'd1;
                  consec_d   = '0;
                  state_d    = LOCKED;
               end else begin
                  state_d = HUNT;
`ifdef OCC_GT_CHECKER_SWAP_EN
                  swap_d  = 1'b0;
`endif
               end
            end
            LOCKED: begin
               expected_d = expected_q + 16'd1;
               if (word_ok) begin
                  consec_d = '0;
               end else begin
                  word_err = 1'b1;
                  if (consec_q == 4'(G_ERR_THRESHOLD - 1)) begin
                     state_d   = HUNT;
                     lock_loss = 1'b1;
                     consec_d  = '0;
`ifdef OCC_GT_CHECKER_SWAP_EN
                     swap_d    = 1'b0;
`endif
                  end else begin
                     consec_d = consec_q + 4'd1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         expected_q <= '0;
         consec_q   <= '0;
         err_o      <= 1'b0;
         locked_o   <= 1'b0;
`ifdef OCC_GT_CHECKER_SWAP_EN
         swap_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         consec_q   <= consec_d;
         err_o      <= word_err;
         locked_o   <= (state_d == LOCKED);
`ifdef OCC_GT_CHECKER_SWAP_EN
         swap_q     <= swap_d;
`endif
      end
   end

   occ_sat_counter #(.WIDTH(G_CNT_WIDTH)) u_err_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (clear_i),
      .inc   (word_err),
      .count (err_cnt_o)
   );

   occ_sat_counter #(.WIDTH(G_CNT_WIDTH)) u_code_err_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (clear_i),
      .inc   (code_err),
      .count (code_err_cnt_o)
   );

   occ_sat_counter #(.WIDTH(8)) u_lock_loss_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (clear_i),
      .inc   (lock_loss),
      .count (lock_loss_cnt_o)
   );

endmodule
